// File: rtl/rdata_chan_subo_pbuf.sv
// AXI R-channel subordinate: DEPTH-entry pending buffer of read lines, each streamed as len+1 beats.
// Latency: line pushed into an empty buffer at edge N shows rvalid from cycle N+1; bursts run back-to-back.
// Backpressure: rdata_s_ready = ~full only; outputs hold while rvalid & ~rready. Option: RDATA_SUBO_ERR_EN.
module rdata_chan_subo_pbuf #(
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 4,
    parameter int ID_W      = 4,
    parameter int DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          rvalid,
    input  logic                          rready,
    output logic [ID_W-1:0]               rid,
    output logic [DATA_W-1:0]             rdata,
    output logic [1:0]                    rresp,
    output logic                          rlast,
    input  logic                          rdata_s_valid,
    output logic                          rdata_s_ready,
    input  logic [ID_W-1:0]               rdata_s_id,
    input  logic [$clog2(MAX_BEATS)-1:0]  rdata_s_len,
    input  logic [DATA_W*MAX_BEATS-1:0]   rdata_s_data,
    input  logic                          rdata_s_err,
    output logic                          finish_rdata_s
);

    localparam int LEN_W = $clog2(MAX_BEATS);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BOUT = 2'd1,
        LAST = 2'd2
    } state_t;

    logic [ID_W-1:0]                  mem_id   [DEPTH];
    logic [LEN_W-1:0]                 mem_len  [DEPTH];
    logic [MAX_BEATS-1:0][DATA_W-1:0] mem_data [DEPTH];
`ifdef RDATA_SUBO_ERR_EN
    logic                             mem_err  [DEPTH];
`endif

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] head_len;
    logic [LEN_W-1:0] next_len;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty         = (count == '0);
    assign full          = (count == CNT_W'(DEPTH));
    assign rdata_s_ready = ~full;
    assign push          = rdata_s_valid & rdata_s_ready;
    assign pop           = finish_rdata_s;
    assign count_nxt     = count + CNT_W'(push) - CNT_W'(pop);
    assign head_len      = mem_len[rd_ptr];
    // With one entry left, the follower can only be the line being pushed this same edge.
    assign next_len      = (count > CNT_W'(1)) ? mem_len[ptr_inc(rd_ptr)] : rdata_s_len;

    assign rvalid         = (state == BOUT) || (state == LAST);
    assign rlast          = (state == LAST);
    assign rid            = empty ? '0 : mem_id[rd_ptr];
    assign rdata          = empty ? '0 : mem_data[rd_ptr][beat_cnt];
    assign finish_rdata_s = rvalid & rready & rlast;

`ifdef RDATA_SUBO_ERR_EN
    assign rresp = (!empty && mem_err[rd_ptr]) ? 2'b10 : 2'b00;
`else
    logic unused_err;
    assign unused_err = rdata_s_err;
    assign rresp      = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]   <= rdata_s_id;
            mem_len[wr_ptr]  <= rdata_s_len;
            mem_data[wr_ptr] <= rdata_s_data;
`ifdef RDATA_SUBO_ERR_EN
            mem_err[wr_ptr]  <= rdata_s_err;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;

            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (!empty) state <= (head_len == '0) ? LAST : BOUT;
                end
                BOUT: begin
                    if (rready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt + 1'b1 == head_len) state <= LAST;
                    end
                end
                LAST: begin
                    if (rready) begin
                        beat_cnt <= '0;
                        if (count_nxt != '0) state <= (next_len == '0) ? LAST : BOUT;
                        else                 state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rdata_chan_subo_pbuf.sv
// Bench for rdata_chan_subo_pbuf: table of lines with hand-written expected beats, scoreboard queue
// checked at negedge on every accepted beat, plus directed latency/stall/reset/error sequences.
module tb_rdata_chan_subo_pbuf;

    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 4;
    localparam int ID_W      = 4;
    localparam int DEPTH     = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         rvalid;
    logic         rready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rdata_s_valid;
    logic         rdata_s_ready;
    logic [3:0]   rdata_s_id;
    logic [1:0]   rdata_s_len;
    logic [127:0] rdata_s_data;
    logic         rdata_s_err;
    logic         finish_rdata_s;

    always #5 clk = ~clk;

    rdata_chan_subo_pbuf #(
        .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .ID_W(ID_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rdata_s_valid(rdata_s_valid), .rdata_s_ready(rdata_s_ready), .rdata_s_id(rdata_s_id),
        .rdata_s_len(rdata_s_len), .rdata_s_data(rdata_s_data), .rdata_s_err(rdata_s_err),
        .finish_rdata_s(finish_rdata_s)
    );

    typedef struct packed {
        logic [3:0]       id;
        logic [1:0]       len;
        logic [127:0]     data;
        logic             err;
        logic [3:0][31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    vec_t  tbl [5];
    beat_t sbq [$];

    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    int fin_cnt = 0;
    int rdy_mode = 0;
    bit prev_stall = 0;
    logic [38:0] prev_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // rready driver: 0 = low, 1 = high, 2 = random per cycle
    initial begin
        rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rready = 1'b0;
                1:       rready = 1'b1;
                default: rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {rvalid, rid, rdata, rlast, rresp}, {1'b1, prev_b});
            if (rvalid && rready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got id %0h data %0h, none expected", rid, rdata);
                end else begin
                    beat_t e;
                    e = sbq.pop_front();
                    chk("beat", {rid, rdata, rlast, rresp, finish_rdata_s},
                        {e.id, e.data, e.last, e.resp, e.last});
                end
                beats_seen++;
            end
            if (finish_rdata_s) fin_cnt++;
            prev_stall = rvalid && !rready;
            prev_b     = {rid, rdata, rlast, rresp};
        end
    end

    task automatic push_line(input logic [3:0] id, input logic [1:0] len, input logic [127:0] data,
                             input logic err, input logic [3:0][31:0] exp);
        beat_t      b;
        logic [1:0] resp;
        bit         got = 0;
`ifdef RDATA_SUBO_ERR_EN
        resp = err ? 2'b10 : 2'b00;
`else
        resp = 2'b00;
`endif
        rdata_s_valid = 1'b1;
        rdata_s_id    = id;
        rdata_s_len   = len;
        rdata_s_data  = data;
        rdata_s_err   = err;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (rdata_s_ready) begin
                for (int k = 0; k <= int'(len); k++) begin
                    b.id   = id;
                    b.data = exp[k];
                    b.last = (k == int'(len));
                    b.resp = resp;
                    sbq.push_back(b);
                end
                got = 1;
                @(posedge clk);
                #1;
            end
        end
        rdata_s_valid = 1'b0;
        if (!got) chk("push_timeout", 0, 1);
    endtask

    task automatic push_vec(input int i);
        push_line(tbl[i].id, tbl[i].len, tbl[i].data, tbl[i].err, tbl[i].exp);
    endtask

    task automatic wait_drain(input int bound);
        bit done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk);
            #1;
            if (sbq.size() == 0 && !rvalid) done = 1;
        end
        chk("drain", done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, last_c, nhs, f0, n0, target;
        bit reached;

        tbl[0] = '{id: 4'd3, len: 2'd3, err: 1'b0,
                   data: 128'h44444444_33333333_22222222_11111111,
                   exp: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}};
        tbl[1] = '{id: 4'd1, len: 2'd0, err: 1'b0,
                   data: 128'hdead0003_dead0002_dead0001_cafe0000,
                   exp: {32'h0, 32'h0, 32'h0, 32'hcafe0000}};
        tbl[2] = '{id: 4'd5, len: 2'd1, err: 1'b1,
                   data: 128'h77777777_66666666_a5a5a5a5_5a5a5a5a,
                   exp: {32'h0, 32'h0, 32'ha5a5a5a5, 32'h5a5a5a5a}};
        tbl[3] = '{id: 4'd6, len: 2'd1, err: 1'b0,
                   data: 128'h0000_0000_0000_0000_12345678_9abcdef0,
                   exp: {32'h0, 32'h0, 32'h12345678, 32'h9abcdef0}};
        tbl[4] = '{id: 4'd15, len: 2'd2, err: 1'b0,
                   data: 128'hffffffff_00c0ffee_0badf00d_00000001,
                   exp: {32'h0, 32'h00c0ffee, 32'h0badf00d, 32'h00000001}};

        rst = 1'b1;
        rdata_s_valid = 1'b0;
        rdata_s_id = '0;
        rdata_s_len = '0;
        rdata_s_data = '0;
        rdata_s_err = 1'b0;
        rdy_mode = 1;
        #1;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_finish", finish_rdata_s, 0);
        chk("rst_ready", rdata_s_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // T1: latency and 4-beat burst
        push_vec(0);
        chk("t1_lat_n", rvalid, 0);
        @(posedge clk);
        #1;
        chk("t1_lat_n1", {rvalid, rid, rdata, rlast}, {1'b1, 4'd3, 32'h11111111, 1'b0});
        wait_drain(50);

        // T2: single-beat burst
        push_vec(1);
        chk("t2_lat_n", rvalid, 0);
        @(posedge clk);
        #1;
        chk("t2_single", {rvalid, rlast, finish_rdata_s, rid}, {3'b111, 4'd1});
        @(posedge clk);
        #1;
        chk("t2_idle", rvalid, 0);

        // T3: fill while stalled, then release; 3+4+1 beats must be contiguous
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        push_vec(4);
        push_vec(0);
        chk("t3_full_rdy", rdata_s_ready, 0);
        fork
            push_vec(1);
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("t3_still_full", rdata_s_ready, 0);
                chk("t3_head_id", {rvalid, rid, rdata}, {1'b1, 4'd15, 32'h00000001});
                rdy_mode = 1;
                first = -1; last_c = -1; nhs = 0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (rvalid && rready) begin
                        if (first < 0) first = c;
                        last_c = c;
                        nhs++;
                    end
                end
                chk("t3_beats", nhs, 8);
                chk("t3_no_gap", last_c - first + 1, 8);
            end
        join
        wait_drain(50);

        // Whole table back-to-back under random rready
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) push_vec(i);
        wait_drain(500);

        // T4: 200 random bursts
        f0 = fin_cnt;
        for (int n = 0; n < 200; n++) begin
            logic [127:0] d;
            d = {$urandom, $urandom, $urandom, $urandom};
            push_line(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), d, 1'b0, d);
        end
        wait_drain(5000);
        chk("t4_finish_cnt", fin_cnt - f0, 200);

        // T5: reset during beat 2 of 4
        rdy_mode = 1;
        @(posedge clk);
        #1;
        target = beats_seen + 1;
        push_vec(0);
        reached = 0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(posedge clk);
            if (beats_seen >= target) reached = 1;
        end
        #1;
        chk("t5_reached", reached, 1);
        chk("t5_beat2", {rvalid, rdata}, {1'b1, 32'h22222222});
        rst = 1'b1;
        #1;
        chk("t5_rst_out", {rvalid, rlast, finish_rdata_s, rid, rdata, rresp}, 0);
        chk("t5_rst_ready", rdata_s_ready, 1);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n0 = beats_seen;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_stale", beats_seen - n0, 0);
        chk("t5_idle", rvalid, 0);

        // T6: error response per burst (00 without the option)
        push_vec(2);
        push_vec(3);
        wait_drain(50);
        chk("end_ready", rdata_s_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
